// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one uartTx byte transmitter
// between N requesters, with an optional channel tag byte and a stall timeout.
module uart_tx_arbiter #(
    parameter int         N          = 4,
    parameter bit         TAG_ENABLE = 1'b1,
    parameter logic [7:0] TAG_BASE   = 8'hF0,
    parameter int         TIMEOUT    = 1024,
    parameter int         TW         = 16
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic [N-1:0]     iReqValid,
    input  logic [8*N-1:0]   iReqData,
    input  logic [N-1:0]     iReqLast,
    output logic [N-1:0]     oReqAck,
    output logic [N-1:0]     oGrant,
    output logic             oBusy,
    output logic             oAbort,
    output logic [7:0]       oTxData,
    output logic             oTxStart,
    input  logic             iTxReady,
    input  logic             iTxTaken
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, TAG, DATA} state_t;

    state_t          state_reg;
    logic [IW-1:0]   ptr_reg;
    logic [IW-1:0]   idx_reg;
    logic [N-1:0]    grant_reg;
    logic [N-1:0]    ack_reg;
    logic            abort_reg;
    logic            pending_reg;
    logic            sent_reg;
    logic            last_reg;
    logic [7:0]      tx_data_reg;
    logic            tx_start_reg;
    logic [TW-1:0]   tout_reg;

    logic [7:0]      req_byte [N];
    logic [IW:0]     cand;
    logic [IW-1:0]   pick_idx;
    logic [N-1:0]    pick_onehot;
    logic            pick_found;
    logic [IW-1:0]   next_ptr;
    logic            valid_g;
    logic            taken_ok;
    logic            timeout_hit;

    for (genvar gi = 0; gi < N; gi++) begin : g_unpack
        assign req_byte[gi] = iReqData[8*gi +: 8];
    end

    // First valid requester at or after ptr, wrapping modulo N.
    always_comb begin
        cand        = '0;
        pick_found  = 1'b0;
        pick_idx    = '0;
        pick_onehot = '0;
        for (int k = 0; k < N; k++) begin
            cand = {1'b0, ptr_reg} + (IW+1)'(k);
            if (cand >= (IW+1)'(N)) cand = cand - (IW+1)'(N);
            if (!pick_found && iReqValid[cand[IW-1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = cand[IW-1:0];
            end
        end
        pick_onehot[pick_idx] = 1'b1;
    end

    assign next_ptr    = (idx_reg == IW'(N-1)) ? '0 : idx_reg + IW'(1);
    assign valid_g     = iReqValid[idx_reg];
    // A taken pulse only completes a byte the transmitter was actually seen to accept.
    assign taken_ok    = sent_reg && iTxTaken;
    assign timeout_hit = (TIMEOUT != 0) && (int'(tout_reg) == TIMEOUT - 1);

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_reg    <= IDLE;
            ptr_reg      <= '0;
            idx_reg      <= '0;
            grant_reg    <= '0;
            ack_reg      <= '0;
            abort_reg    <= 1'b0;
            pending_reg  <= 1'b0;
            sent_reg     <= 1'b0;
            last_reg     <= 1'b0;
            tx_data_reg  <= '0;
            tx_start_reg <= 1'b0;
            tout_reg     <= '0;
        end else begin
            ack_reg   <= '0;
            abort_reg <= 1'b0;
            if (pending_reg && tx_start_reg && iTxReady) sent_reg <= 1'b1;

            if (state_reg != DATA || valid_g) tout_reg <= '0;
            else if (!pending_reg && tout_reg != '1) tout_reg <= tout_reg + TW'(1);

            case (state_reg)
                IDLE: begin
                    if (pick_found) begin
                        grant_reg <= pick_onehot;
                        idx_reg   <= pick_idx;
                        state_reg <= TAG_ENABLE ? TAG : DATA;
                    end
                end
                TAG: begin
                    if (!pending_reg) begin
                        tx_data_reg  <= TAG_BASE + 8'(idx_reg);
                        tx_start_reg <= 1'b1;
                        pending_reg  <= 1'b1;
                    end else if (taken_ok) begin
                        tx_start_reg <= 1'b0;
                        pending_reg  <= 1'b0;
                        sent_reg     <= 1'b0;
                        state_reg    <= DATA;
                    end
                end
                DATA: begin
                    if (pending_reg) begin
                        if (taken_ok) begin
                            tx_start_reg <= 1'b0;
                            pending_reg  <= 1'b0;
                            sent_reg     <= 1'b0;
                            if (last_reg) begin
                                state_reg <= IDLE;
                                grant_reg <= '0;
                                ptr_reg   <= next_ptr;
                            end
                        end
                    end else if (valid_g) begin
                        tx_data_reg      <= req_byte[idx_reg];
                        last_reg         <= iReqLast[idx_reg];
                        tx_start_reg     <= 1'b1;
                        pending_reg      <= 1'b1;
                        ack_reg[idx_reg] <= 1'b1;
                    end else if (timeout_hit) begin
                        // Nothing is in flight here, so releasing loses no byte.
                        abort_reg <= 1'b1;
                        grant_reg <= '0;
                        ptr_reg   <= next_ptr;
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign oReqAck  = ack_reg;
    assign oGrant   = grant_reg;
    assign oAbort   = abort_reg;
    assign oTxData  = tx_data_reg;
    assign oTxStart = tx_start_reg;
    assign oBusy    = (state_reg != IDLE) || pending_reg;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: requester drivers, a uartTx stub and
// a monitor that checks every byte accepted by the transmitter.
module tb_uart_tx_arbiter;
    localparam int N       = 4;
    localparam int TIMEOUT = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req_valid;
    logic [8*N-1:0]   req_data;
    logic [N-1:0]     req_last;
    logic [N-1:0]     ack;
    logic [N-1:0]     grant;
    logic             busy;
    logic             abort_p;
    logic [7:0]       tx_data;
    logic             tx_start;
    logic             tx_ready;
    logic             tx_taken;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .N(N), .TAG_ENABLE(1'b1), .TAG_BASE(8'hF0), .TIMEOUT(TIMEOUT), .TW(16)
    ) dut (
        .iClk(clk), .iRst(rst),
        .iReqValid(req_valid), .iReqData(req_data), .iReqLast(req_last),
        .oReqAck(ack), .oGrant(grant), .oBusy(busy), .oAbort(abort_p),
        .oTxData(tx_data), .oTxStart(tx_start),
        .iTxReady(tx_ready), .iTxTaken(tx_taken)
    );

    typedef struct { logic [7:0] d; logic l; int gap; } item_t;
    typedef struct { logic [7:0] b; logic [N-1:0] g; } exp_t;

    item_t tab [N][16];
    int    tab_n [N];
    int    exp_ack [N];
    exp_t  exp_q [$];
    int    checks;
    int    errors;

    int    ack_cnt [N];
    int    abort_cnt, abort_delta, acc_cnt, taken_cnt, cyc, last_taken_cyc;
    logic [N-1:0] abort_grant;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, expv);
        end
    endtask

    // uartTx stub: accepts on ready&start, pulses taken next cycle, busy for tx_delay.
    logic ready_int, hold_low;
    int   busy_cnt, tx_delay;
    assign tx_ready = ready_int && !hold_low;
    always @(posedge clk) begin
        if (rst) begin
            ready_int <= 1'b1;
            tx_taken  <= 1'b0;
            busy_cnt  <= 0;
        end else begin
            tx_taken <= 1'b0;
            if (tx_ready && tx_start) begin
                ready_int <= 1'b0;
                tx_taken  <= 1'b1;
                busy_cnt  <= tx_delay;
            end else if (!ready_int) begin
                if (busy_cnt == 0) ready_int <= 1'b1;
                else busy_cnt <= busy_cnt - 1;
            end
        end
    end

    // Requester drivers: hold each byte until its ack, change it the cycle after.
    for (genvar gi = 0; gi < N; gi++) begin : g_drv
        logic       v;
        logic [7:0] d;
        logic       l;
        assign req_valid[gi]       = v;
        assign req_data[8*gi +: 8] = d;
        assign req_last[gi]        = l;
        initial begin
            int rd;
            int w;
            v = 1'b0; d = 8'h00; l = 1'b0; rd = 0;
            forever begin
                @(posedge clk); #1;
                while (rd < tab_n[gi]) begin
                    v = 1'b0;
                    for (int k = 0; k < tab[gi][rd].gap; k++) begin
                        @(posedge clk); #1;
                    end
                    d = tab[gi][rd].d;
                    l = tab[gi][rd].l;
                    v = 1'b1;
                    w = 0;
                    do begin
                        @(negedge clk);
                        w++;
                    end while (!ack[gi] && w < 4000);
                    @(posedge clk); #1;
                    rd++;
                end
                v = 1'b0;
            end
        end
    end

    // Monitor: scoreboard pop on each transmitter accept, plus hold/ack/abort tracking.
    initial begin
        logic [7:0] hold_data;
        logic       hold_valid;
        exp_t       e;
        hold_valid = 1'b0; hold_data = 8'h00;
        abort_cnt = 0; abort_delta = 0; acc_cnt = 0; taken_cnt = 0;
        cyc = 0; last_taken_cyc = 0; abort_grant = '0;
        for (int r = 0; r < N; r++) ack_cnt[r] = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                hold_valid = 1'b0;
            end else begin
                for (int r = 0; r < N; r++) if (ack[r]) ack_cnt[r]++;
                if (abort_p) begin
                    abort_cnt++;
                    abort_delta = cyc - last_taken_cyc;
                    abort_grant = grant;
                end
                if (tx_ready && tx_start) begin
                    acc_cnt++;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_byte: got %02h grant %b, queue empty", tx_data, grant);
                    end else begin
                        e = exp_q.pop_front();
                        $display("tx byte %02h grant %b (expected %02h grant %b)", tx_data, grant, e.b, e.g);
                        check("tx_byte", 32'(tx_data), 32'(e.b));
                        check("tx_grant", 32'(grant), 32'(e.g));
                    end
                end
                if (tx_start) begin
                    if (!hold_valid) begin
                        hold_valid = 1'b1;
                        hold_data  = tx_data;
                    end else if (tx_data !== hold_data) begin
                        check("tx_data_stable", 32'(tx_data), 32'(hold_data));
                    end
                end else if (hold_valid) begin
                    check("tx_start_held", 32'(tx_start), 32'd1);
                    hold_valid = 1'b0;
                end
                if (tx_taken) begin
                    taken_cnt++;
                    last_taken_cyc = cyc;
                    if (hold_valid) check("tx_data_at_taken", 32'(tx_data), 32'(hold_data));
                    hold_valid = 1'b0;
                end
            end
        end
    end

    task automatic push_req(input int r, input logic [7:0] d, input logic l, input int gap);
        tab[r][tab_n[r]].d   = d;
        tab[r][tab_n[r]].l   = l;
        tab[r][tab_n[r]].gap = gap;
        tab_n[r]++;
        exp_ack[r]++;
    endtask

    task automatic push_exp(input logic [7:0] b, input logic [N-1:0] g);
        exp_t e;
        e.b = b;
        e.g = g;
        exp_q.push_back(e);
    endtask

    task automatic wait_idle(input string name);
        int quiet;
        int n;
        quiet = 0;
        n = 0;
        while (quiet < 4 && n < 3000) begin
            @(negedge clk);
            n++;
            if (exp_q.size() == 0 && !busy && req_valid == '0) quiet++;
            else quiet = 0;
        end
        check({name, "_idle"}, 32'(quiet >= 4), 32'd1);
        check({name, "_grant_idle"}, 32'(grant), 32'd0);
        for (int r = 0; r < N; r++) check({name, "_ack_count"}, 32'(ack_cnt[r]), 32'(exp_ack[r]));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        checks = 0;
        errors = 0;
        for (int r = 0; r < N; r++) begin
            tab_n[r]   = 0;
            exp_ack[r] = 0;
        end
        tx_delay = 2;
        hold_low = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_grant", 32'(grant), 32'd0);
        check("reset_start", 32'(tx_start), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_ack", 32'(ack), 32'd0);
        check("reset_abort", 32'(abort_p), 32'd0);
        check("reset_txdata", 32'(tx_data), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // All four requesters at once from ptr=0, req0 refilled immediately.
        @(negedge clk);
        push_req(0, 8'hA0, 1'b1, 0);
        push_req(0, 8'hA4, 1'b1, 0);
        push_req(1, 8'hA1, 1'b1, 0);
        push_req(2, 8'hA2, 1'b1, 0);
        push_req(3, 8'hA3, 1'b1, 0);
        push_exp(8'hF0, 4'b0001); push_exp(8'hA0, 4'b0001);
        push_exp(8'hF1, 4'b0010); push_exp(8'hA1, 4'b0010);
        push_exp(8'hF2, 4'b0100); push_exp(8'hA2, 4'b0100);
        push_exp(8'hF3, 4'b1000); push_exp(8'hA3, 4'b1000);
        push_exp(8'hF0, 4'b0001); push_exp(8'hA4, 4'b0001);
        wait_idle("rr_all");

        // Two-byte packet from req2 (ptr=1).
        push_req(2, 8'h11, 1'b0, 0);
        push_req(2, 8'h22, 1'b1, 0);
        push_exp(8'hF2, 4'b0100); push_exp(8'h11, 4'b0100); push_exp(8'h22, 4'b0100);
        wait_idle("single_pkt");

        // ptr should now be 3: req3 beats req0.
        push_req(0, 8'h40, 1'b1, 0);
        push_req(3, 8'h43, 1'b1, 0);
        push_exp(8'hF3, 4'b1000); push_exp(8'h43, 4'b1000);
        push_exp(8'hF0, 4'b0001); push_exp(8'h40, 4'b0001);
        wait_idle("ptr_after_pkt");

        // Mid-packet stall shorter than the timeout keeps the grant.
        push_req(1, 8'h51, 1'b0, 0);
        push_req(1, 8'h52, 1'b1, 12);
        push_exp(8'hF1, 4'b0010); push_exp(8'h51, 4'b0010); push_exp(8'h52, 4'b0010);
        wait_idle("stall");
        check("stall_no_abort", 32'(abort_cnt), 32'd0);

        // Timeout: req1 goes silent after one byte, waiting req2 is served next.
        push_req(1, 8'h61, 1'b0, 0);
        push_exp(8'hF1, 4'b0010); push_exp(8'h61, 4'b0010);
        n = 0;
        while (grant != 4'b0010 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("timeout_grant1", 32'(grant), 32'b0010);
        push_req(2, 8'h62, 1'b1, 0);
        push_exp(8'hF2, 4'b0100); push_exp(8'h62, 4'b0100);
        wait_idle("timeout");
        check("abort_count", 32'(abort_cnt), 32'd1);
        check("abort_delay", 32'(abort_delta), 32'd17);
        check("abort_grant", 32'(abort_grant), 32'd0);

        // Slow transmitter: bytes stay stable for 50 cycles.
        tx_delay = 50;
        push_req(2, 8'h71, 1'b0, 0);
        push_req(2, 8'h72, 1'b1, 0);
        push_exp(8'hF2, 4'b0100); push_exp(8'h71, 4'b0100); push_exp(8'h72, 4'b0100);
        wait_idle("slow_tx");
        check("taken_per_byte", 32'(taken_cnt), 32'(acc_cnt));
        tx_delay = 2;

        // Reset while the tag byte is pending; ptr must restart at 0.
        hold_low = 1'b1;
        push_req(3, 8'h55, 1'b1, 0);
        n = 0;
        while (!tx_start && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("rst_pending_start", 32'(tx_start), 32'd1);
        check("rst_pending_grant", 32'(grant), 32'b1000);
        push_req(1, 8'h56, 1'b1, 0);
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        hold_low = 1'b0;
        push_exp(8'hF1, 4'b0010); push_exp(8'h56, 4'b0010);
        push_exp(8'hF3, 4'b1000); push_exp(8'h55, 4'b1000);
        @(negedge clk);
        check("midrst_start", 32'(tx_start), 32'd0);
        check("midrst_grant", 32'(grant), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        wait_idle("after_reset");
        check("taken_total", 32'(taken_cnt), 32'(acc_cnt));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares one uartTx byte transmitter between N requesters with packet-granular round-robin arbitration. A grant is held from a requester's first byte until the byte flagged last has been handed to the transmitter. An optional channel tag byte is sent before each packet, so the host can demultiplex the stream. A stall timeout stops a silent requester from locking the UART.

Parameters:
N, 4, number of requesters (2..8)
TAG_ENABLE, 1, 1 = send one tag byte (TAG_BASE + grant index) before each packet
TAG_BASE, 8'hF0, base value of the tag byte
TIMEOUT, 1024, idle cycles with a held grant before forced release; 0 = disabled
TW, 16, timeout counter width

Ports:
iClk  in  1  clock
iRst  in  1  synchronous active-high reset
iReqValid  in  N  requester i has a byte on iReqData[8i+7:8i]
iReqData  in  8*N  packed request bytes
iReqLast  in  N  byte is the final byte of the packet
oReqAck  out  N  one-cycle pulse: byte consumed; requester may change valid/data/last from the next cycle
oGrant  out  N  one-hot current owner; 0 when idle
oBusy  out  1  state != IDLE or byte pending
oAbort  out  1  one-cycle pulse on timeout release
oTxData  out  8  to uartTx iData
oTxStart  out  1  to uartTx iStart
iTxReady  in  1  from uartTx oReady
iTxTaken  in  1  from uartTx oTaken (pulse, cycle after accept)

Behaviour:
- Reset: iRst is synchronous, active-high; clock is iClk. Reset clears all outputs, state=IDLE, ptr=0, pending=0 and the timeout counter. Reset mid-byte drops oTxStart the next cycle; uartTx is reset by the same iRst.
- States:
  - IDLE: when any iReqValid is high, pick the first set bit at or after ptr (wrapping mod N) and load oGrant. Go to TAG if TAG_ENABLE, otherwise to DATA. The choice takes one cycle.
  - TAG: if pending=0, load oTxData=TAG_BASE+idx, set oTxStart=1 and pending=1. When iTxTaken arrives, clear oTxStart and pending and go to DATA. No oReqAck is issued for the tag.
  - DATA: if pending=0 and iReqValid[g] is high, in the same edge:
    - latch oTxData=iReqData[g] and lastLatched=iReqLast[g];
    - set oTxStart=1 and pending=1;
    - pulse oReqAck[g] in the next cycle.
  - DATA, on iTxTaken: clear oTxStart and pending. If lastLatched, go to IDLE, clear oGrant and set ptr=(g+1) mod N.
- Transmitter handshake:
  - oTxStart and oTxData are held stable until iTxTaken.
  - uartTx accepts when iTxReady & oTxStart. iTxTaken follows one cycle later; iTxReady is already low by then, so the extra start cycle is harmless.
  - No new byte is latched while pending=1, so there are at most 1 byte in flight.
- Earliest sampling: after an ack, the next request byte is sampled no earlier than 3 cycles after the latch edge.
- Requester rules:
  - valid, data and last must stay stable until ack.
  - A requester may drop valid between bytes of a packet; the grant is kept.
  - Non-granted requesters are ignored. A valid bit may rise in any state.
- Timeout (TIMEOUT>0):
  - The counter increments in DATA while pending=0 and iReqValid[g]=0.
  - It clears on any latch, or when iReqValid[g] is high.
  - When it reaches TIMEOUT: pulse oAbort, clear oGrant, set ptr=g+1, go to IDLE. No byte is lost, since pending=0 at that point.
  - The counter saturates at TW bits.
- Simultaneous events: iTxTaken for the last byte while other requesters are valid → IDLE for one cycle, then the next grant follows round-robin.
- Zero-length packets are impossible: last is carried on a real byte.
- Tag arithmetic: 8-bit add, wraps modulo 256.

Test Plan:
- Single packet, N=4, TAG_ENABLE=1: req2 sends 8'h11, 8'h22(last) → UART line bytes F2,11,22; two oReqAck[2] pulses; oGrant=0100 then 0; ptr=3.
- All four requesters valid, each with a 1-byte packet A0..A3 and ptr=0 → order F0,A0,F1,A1,F2,A2,F3,A3; with req0 refilled immediately, it is served after req3.
- Mid-packet stall: req1 sends 1 byte and then drops valid for 20 cycles with TIMEOUT=1024 → grant held; packet completes after valid returns; no oAbort.
- Timeout: TIMEOUT=16, req1 drops valid after its first byte → oAbort pulses exactly 16 cycles after the counter starts; oGrant=0; waiting req2 is granted next.
- Handshake check with uartTx stub that delays iTxReady 50 cycles → oTxStart and oTxData stay stable throughout; one iTxTaken per byte; no duplicated or dropped bytes.
- Reset mid-byte while pending=1 → next cycle: oTxStart=0, oGrant=0, oBusy=0, ptr=0; a fresh request after reset is sent intact with its tag.
